// File: rtl/csi_pkg.sv
// Purpose: shared types and constants for the CSI-2 packet sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a; the sequencer path has no ready signal.
//
// Contents: sequencer FSM states, CSI-2 data-type codes, default line word
// count and byte delay, payload beat struct, frame-number increment helper.
package csi_pkg;

    // CSI-2 data types emitted by the sequencer
    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_RAW10 = 6'h2B;

    // 256 RAW10 pixels pack into 320 bytes
    localparam logic [15:0] DEFAULT_WC         = 16'd320;
    localparam int          DEFAULT_DATA_DELAY = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        LINE  = 2'd2
    } seq_state_t;

    // One payload byte slot as it travels down the delay line
    typedef struct packed {
        logic       en;
        logic [7:0] dat;
    } byte_beat_t;

    // Frame numbers run 1..FFFF; zero means "not used" on the CSI link
    function automatic logic [15:0] next_frame_num(input logic [15:0] cur);
        return (cur == 16'hFFFF) ? 16'd1 : cur + 16'd1;
    endfunction

endpackage

// File: rtl/csi_delay_line.sv
// Purpose: fixed-depth register pipeline that delays a word by DEPTH cycles.
// Latency: exactly DEPTH clk cycles, one new word accepted every cycle.
// Backpressure: none; the line never stalls, so order and spacing are kept.
//
// Ports: clk, reset (sync, active-high, clears every stage), in_dat, out_dat.
// DEPTH must be at least 1.
module csi_delay_line #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_dat,
    output logic [WIDTH-1:0] out_dat
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= in_dat;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_dat = stage[DEPTH-1];

endmodule

// File: rtl/csi_packet_sequencer.sv
// Purpose: turns pix2byte frame/line events into CSI-2 FS/FE/long-packet requests.
// Latency: strobes, dt/wc and line_error one cycle after the event; payload DATA_DELAY cycles.
// Backpressure: none; every event and byte is consumed the cycle it is presented.
//
// Ports:
//   clk, reset                   byte clock, synchronous active-high reset
//   fv_start_i/fv_end_i          frame start/end pulses
//   lv_start_i/lv_end_i          line start/end pulses
//   byte_en_i/byte_data_i        payload byte stream in
//   sp_en_o/lp_en_o, dt_o, wc_o  packet requests to csi_tx
//   byte_en_o/byte_data_o        delayed payload to csi_tx
//   frame_active_o, line_error_o, err_count_o  status
// Build option: define CSI_FRAME_NUMBER_EN to carry a 1..FFFF frame number in
// the FS/FE word count; otherwise FS/FE carry zero.
module csi_packet_sequencer
    import csi_pkg::*;
#(
    parameter logic [15:0] WC         = DEFAULT_WC,
    parameter int          DATA_DELAY = DEFAULT_DATA_DELAY  // 1..8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fv_start_i,
    input  logic        fv_end_i,
    input  logic        lv_start_i,
    input  logic        lv_end_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_data_i,
    output logic        sp_en_o,
    output logic        lp_en_o,
    output logic [5:0]  dt_o,
    output logic [15:0] wc_o,
    output logic        byte_en_o,
    output logic [7:0]  byte_data_o,
    output logic        frame_active_o,
    output logic        line_error_o,
    output logic [7:0]  err_count_o
);

    seq_state_t  state;
    seq_state_t  state_nxt;
    logic [15:0] byte_cnt;
    logic [15:0] byte_cnt_nxt;
    logic        sp_en_nxt;
    logic        lp_en_nxt;
    logic [5:0]  dt_nxt;
    logic [15:0] wc_nxt;
    logic        line_err_nxt;
    logic [7:0]  err_cnt_nxt;
    logic        count_byte;
    logic [15:0] line_total;
    logic [15:0] fs_fe_wc;

    // ---------------------------------------------------------------------
    // Frame number (optional)
    // ---------------------------------------------------------------------
`ifdef CSI_FRAME_NUMBER_EN
    logic [15:0] frame_num;

    // The only way to leave FRAME/LINE for IDLE is an accepted fv_end_i, so
    // this edge advances the number right after the FE has sampled it.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_num <= 16'd1;
        end else if (state != IDLE && state_nxt == IDLE) begin
            frame_num <= next_frame_num(frame_num);
        end
    end

    assign fs_fe_wc = frame_num;
`else
    assign fs_fe_wc = 16'd0;
`endif

    // ---------------------------------------------------------------------
    // Next-state / next-output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        sp_en_nxt    = 1'b0;
        lp_en_nxt    = 1'b0;
        dt_nxt       = dt_o;
        wc_nxt       = wc_o;
        line_err_nxt = 1'b0;
        count_byte   = byte_en_i && (state == LINE);
        // Count as it stands including a byte arriving with lv_end_i
        line_total   = byte_cnt + {15'd0, count_byte};

        // Event priority fv_start > fv_end > lv_start > lv_end; an event that
        // is not legal in the current state is dropped and the next one is
        // considered.
        if (fv_start_i) begin
            state_nxt    = FRAME;
            sp_en_nxt    = 1'b1;
            dt_nxt       = DT_FS;
            wc_nxt       = fs_fe_wc;
            // A new frame while one is open means the previous one was lost
            line_err_nxt = (state != IDLE);
        end else if (fv_end_i && state != IDLE) begin
            state_nxt    = IDLE;
            sp_en_nxt    = 1'b1;
            dt_nxt       = DT_FE;
            wc_nxt       = fs_fe_wc;
            // Truncated line: flag it, the partial byte count is meaningless
            line_err_nxt = (state == LINE);
        end else if (lv_start_i && state == FRAME) begin
            state_nxt    = LINE;
            lp_en_nxt    = 1'b1;
            dt_nxt       = DT_RAW10;
            wc_nxt       = WC;
            // A byte on the line-start cycle is the line's first byte
            byte_cnt_nxt = {15'd0, byte_en_i};
        end else if (lv_end_i && state == LINE) begin
            state_nxt    = FRAME;
            byte_cnt_nxt = line_total;
            line_err_nxt = (line_total != WC);
        end else if (count_byte) begin
            byte_cnt_nxt = line_total;
        end

        // Error counter tracks every line_error pulse and sticks at FF
        err_cnt_nxt = err_count_o;
        if (line_err_nxt && err_count_o != 8'hFF) begin
            err_cnt_nxt = err_count_o + 8'd1;
        end
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            byte_cnt     <= 16'd0;
            sp_en_o      <= 1'b0;
            lp_en_o      <= 1'b0;
            dt_o         <= 6'd0;
            wc_o         <= 16'd0;
            line_error_o <= 1'b0;
            err_count_o  <= 8'd0;
        end else begin
            state        <= state_nxt;
            byte_cnt     <= byte_cnt_nxt;
            sp_en_o      <= sp_en_nxt;
            lp_en_o      <= lp_en_nxt;
            dt_o         <= dt_nxt;
            wc_o         <= wc_nxt;
            line_error_o <= line_err_nxt;
            err_count_o  <= err_cnt_nxt;
        end
    end

    assign frame_active_o = (state != IDLE);

    // ---------------------------------------------------------------------
    // Payload delay: aligns bytes behind the long-packet header request
    // ---------------------------------------------------------------------
    byte_beat_t beat_in;
    byte_beat_t beat_out;

    assign beat_in = '{en: byte_en_i, dat: byte_data_i};

    csi_delay_line #(
        .WIDTH ($bits(byte_beat_t)),
        .DEPTH (DATA_DELAY)
    ) u_delay (
        .clk     (clk),
        .reset   (reset),
        .in_dat  (beat_in),
        .out_dat (beat_out)
    );

    assign byte_en_o   = beat_out.en;
    assign byte_data_o = beat_out.dat;

endmodule

// File: tb/tb_csi_packet_sequencer.sv
// Purpose: self-checking bench for csi_packet_sequencer against a frame/line model.
// Latency: model predicts outputs one cycle after events and DLY cycles for payload.
// Backpressure: n/a; stimulus is driven every cycle.
module tb_csi_packet_sequencer;

    localparam logic [15:0] WC_P = 16'd320;
    localparam int          DLY  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        fv_start_i, fv_end_i, lv_start_i, lv_end_i;
    logic        byte_en_i;
    logic [7:0]  byte_data_i;
    logic        sp_en_o, lp_en_o;
    logic [5:0]  dt_o;
    logic [15:0] wc_o;
    logic        byte_en_o;
    logic [7:0]  byte_data_o;
    logic        frame_active_o, line_error_o;
    logic [7:0]  err_count_o;

    always #5 clk = ~clk;

    csi_packet_sequencer #(
        .WC         (WC_P),
        .DATA_DELAY (DLY)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fv_start_i     (fv_start_i),
        .fv_end_i       (fv_end_i),
        .lv_start_i     (lv_start_i),
        .lv_end_i       (lv_end_i),
        .byte_en_i      (byte_en_i),
        .byte_data_i    (byte_data_i),
        .sp_en_o        (sp_en_o),
        .lp_en_o        (lp_en_o),
        .dt_o           (dt_o),
        .wc_o           (wc_o),
        .byte_en_o      (byte_en_o),
        .byte_data_o    (byte_data_o),
        .frame_active_o (frame_active_o),
        .line_error_o   (line_error_o),
        .err_count_o    (err_count_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_frame, m_line;
    int          m_cnt, m_err, m_fnum;
    logic [5:0]  m_dt;
    logic [15:0] m_wc;
    logic [8:0]  m_q[$];
    int          obs_sp, obs_lp, obs_le, obs_be;

    task automatic model_reset();
        m_frame = 0; m_line = 0; m_cnt = 0; m_err = 0; m_fnum = 1;
        m_dt = 6'd0; m_wc = 16'd0;
        m_q.delete();
        for (int i = 0; i < DLY - 1; i++) m_q.push_back(9'd0);
    endtask

    task automatic clear_obs();
        obs_sp = 0; obs_lp = 0; obs_le = 0; obs_be = 0;
    endtask

    // Predict the outputs for this cycle's inputs, clock once, compare.
    task automatic step();
        logic        e_sp, e_lp, e_le;
        logic [8:0]  e_byte;
        logic [15:0] fw;
        e_sp = 0; e_lp = 0; e_le = 0; e_byte = 9'd0;
`ifdef CSI_FRAME_NUMBER_EN
        fw = 16'(m_fnum);
`else
        fw = 16'd0;
`endif
        if (reset) begin
            model_reset();
        end else begin
            if (fv_start_i) begin
                e_le = m_frame; e_sp = 1; m_dt = 6'h00; m_wc = fw;
                m_frame = 1; m_line = 0;
            end else if (fv_end_i && m_frame) begin
                e_le = m_line; e_sp = 1; m_dt = 6'h01; m_wc = fw;
                m_frame = 0; m_line = 0;
                m_fnum = (m_fnum == 65535) ? 1 : m_fnum + 1;
            end else if (lv_start_i && m_frame && !m_line) begin
                e_lp = 1; m_dt = 6'h2B; m_wc = WC_P;
                m_line = 1; m_cnt = byte_en_i ? 1 : 0;
            end else if (lv_end_i && m_line) begin
                e_le = (((m_cnt + (byte_en_i ? 1 : 0)) % 65536) != int'(WC_P));
                m_line = 0;
            end else if (m_line && byte_en_i) begin
                m_cnt = (m_cnt + 1) % 65536;
            end
            if (e_le && m_err < 255) m_err++;
            m_q.push_back({byte_en_i, byte_data_i});
            e_byte = m_q.pop_front();
        end
        @(posedge clk);
        #1;
        check("sp_en", 32'(sp_en_o), 32'(e_sp));
        check("lp_en", 32'(lp_en_o), 32'(e_lp));
        check("line_error", 32'(line_error_o), 32'(e_le));
        check("dt", 32'(dt_o), 32'(m_dt));
        check("wc", 32'(wc_o), 32'(m_wc));
        check("err_count", 32'(err_count_o), 32'(m_err));
        check("frame_active", 32'(frame_active_o), 32'(m_frame));
        check("byte_en", 32'(byte_en_o), 32'(e_byte[8]));
        if (e_byte[8]) check("byte_data", 32'(byte_data_o), 32'(e_byte[7:0]));
        obs_sp += int'(sp_en_o);
        obs_lp += int'(lp_en_o);
        obs_le += int'(line_error_o);
        obs_be += int'(byte_en_o);
    endtask

    task automatic drive(input bit fvs, input bit fve, input bit lvs, input bit lve,
                         input bit be, input logic [7:0] d);
        fv_start_i = fvs; fv_end_i = fve; lv_start_i = lvs; lv_end_i = lve;
        byte_en_i = be; byte_data_i = d;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle(n);
        reset = 1'b0;
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 1, 8'($urandom));
    endtask

    task automatic send_line(input int n);
        drive(0, 0, 1, 0, 0, 8'h00);
        send_bytes(n);
        drive(0, 0, 0, 1, 0, 8'h00);
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        fv_start_i = 0; fv_end_i = 0; lv_start_i = 0; lv_end_i = 0;
        byte_en_i = 0; byte_data_i = 8'h00;
        model_reset();
        clear_obs();

        // Reset state
        do_reset(3);
        check("rst_dt", 32'(dt_o), 32'h0);
        check("rst_wc", 32'(wc_o), 32'h0);
        check("rst_err_count", 32'(err_count_o), 32'h0);
        check("rst_frame_active", 32'(frame_active_o), 32'h0);

        // Payload latency with a lone byte
        drive(0, 0, 0, 0, 1, 8'hA5);
        lat = 1;
        while (!byte_en_o && lat < 10) begin
            idle(1);
            lat++;
        end
        check("byte_latency", 32'(lat), 32'(DLY));
        check("byte_latency_data", 32'(byte_data_o), 32'hA5);
        idle(DLY + 1);

        // One frame of 8 full lines
        clear_obs();
        drive(1, 0, 0, 0, 0, 8'h00);
        check("frame_fs_dt", 32'(dt_o), 32'h00);
        for (int l = 0; l < 8; l++) begin
            send_line(int'(WC_P));
            idle(2);
        end
        drive(0, 1, 0, 0, 0, 8'h00);
        check("frame_fe_dt", 32'(dt_o), 32'h01);
        idle(DLY + 1);
        check("frame_sp_count", 32'(obs_sp), 32'd2);
        check("frame_lp_count", 32'(obs_lp), 32'd8);
        check("frame_line_errors", 32'(obs_le), 32'd0);
        check("frame_bytes_out", 32'(obs_be), 32'(8 * int'(WC_P)));

        // Short line of WC-1 bytes
        clear_obs();
        drive(1, 0, 0, 0, 0, 8'h00);
        send_line(int'(WC_P) - 1);
        idle(1);
        check("short_line_error", 32'(obs_le), 32'd1);
        check("short_err_count", 32'(err_count_o), 32'd1);
        drive(0, 1, 0, 0, 0, 8'h00);
        idle(DLY);

        // fv_start and lv_start together from IDLE
        drive(1, 0, 1, 0, 0, 8'h00);
        check("coinc_sp", 32'(sp_en_o), 32'd1);
        check("coinc_lp", 32'(lp_en_o), 32'd0);
        check("coinc_dt", 32'(dt_o), 32'h00);
        check("coinc_active", 32'(frame_active_o), 32'd1);
        clear_obs();
        send_line(int'(WC_P));
        check("coinc_then_line", 32'(obs_lp), 32'd1);
        drive(0, 1, 0, 0, 0, 8'h00);
        idle(DLY);

        // fv_end in the middle of a line
        drive(1, 0, 0, 0, 0, 8'h00);
        drive(0, 0, 1, 0, 0, 8'h00);
        send_bytes(50);
        drive(0, 1, 0, 0, 0, 8'h00);
        check("midline_fe_sp", 32'(sp_en_o), 32'd1);
        check("midline_fe_dt", 32'(dt_o), 32'h01);
        check("midline_fe_err", 32'(line_error_o), 32'd1);
        check("midline_idle", 32'(frame_active_o), 32'd0);
        idle(DLY + 1);

        // Reset after 100 bytes of a line
        drive(1, 0, 0, 0, 0, 8'h00);
        drive(0, 0, 1, 0, 0, 8'h00);
        send_bytes(100);
        reset = 1'b1;
        drive(0, 0, 0, 0, 1, 8'h3C);
        check("rst_mid_byte_en", 32'(byte_en_o), 32'd0);
        check("rst_mid_sp", 32'(sp_en_o), 32'd0);
        check("rst_mid_active", 32'(frame_active_o), 32'd0);
        check("rst_mid_err_count", 32'(err_count_o), 32'd0);
        reset = 1'b0;
        clear_obs();
        idle(DLY + 3);
        check("rst_no_residual", 32'(obs_be), 32'd0);
        check("rst_no_fe", 32'(obs_sp), 32'd0);

        // Error counter saturation: each fv_start inside a frame is an error
        drive(1, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 300; i++) drive(1, 0, 0, 0, 0, 8'h00);
        check("err_saturate", 32'(err_count_o), 32'hFF);
        drive(0, 1, 0, 0, 0, 8'h00);
        check("err_hold", 32'(err_count_o), 32'hFF);
        do_reset(2);

`ifdef CSI_FRAME_NUMBER_EN
        // Frame numbers 1,2,3 then wrap from FFFF
        for (int f = 1; f <= 3; f++) begin
            drive(1, 0, 0, 0, 0, 8'h00);
            check("fnum_fs_wc", 32'(wc_o), 32'(f));
            send_line(int'(WC_P));
            drive(0, 1, 0, 0, 0, 8'h00);
            check("fnum_fe_wc", 32'(wc_o), 32'(f));
        end
        force dut.frame_num = 16'hFFFF;
        #1;
        release dut.frame_num;
        m_fnum = 65535;
        drive(1, 0, 0, 0, 0, 8'h00);
        check("fnum_max_fs", 32'(wc_o), 32'hFFFF);
        drive(0, 1, 0, 0, 0, 8'h00);
        check("fnum_max_fe", 32'(wc_o), 32'hFFFF);
        drive(1, 0, 0, 0, 0, 8'h00);
        check("fnum_wrap_fs", 32'(wc_o), 32'd1);
        drive(0, 1, 0, 0, 0, 8'h00);
        idle(DLY);
`endif

        // Randomized event soup against the model
        do_reset(2);
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 6,
                  $urandom_range(0, 99) < 60, 8'($urandom));
        end
        reset = 1'b0;
        idle(DLY + 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/csi_packet_sequencer.md
CSI_PACKET_SEQUENCER -- requirements
Module: csi_packet_sequencer

Interface
REQ-001 SHALL have parameter WC, default 16'd320, meaning the long-packet word count in bytes (256 px RAW10).
REQ-002 SHALL have parameter DATA_DELAY, default 3, meaning the byte-path pipeline depth in clk cycles, legal range 1..8.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, the byte clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-006 SHALL have ports fv_start_i, fv_end_i, lv_start_i and lv_end_i, each input, 1, a single-cycle event pulse from pix2byte.
REQ-007 SHALL have ports byte_en_i, input, 1, and byte_data_i, input, 8, carrying the payload byte stream from pix2byte.
REQ-008 SHALL have ports sp_en_o and lp_en_o, each output, 1, the short-packet and long-packet strobes to csi_tx.
REQ-009 SHALL have ports dt_o, output, 6, the data type, and wc_o, output, 16, the word count, both to csi_tx.
REQ-010 SHALL have ports byte_en_o, output, 1, and byte_data_o, output, 8, the delayed payload to csi_tx.
REQ-011 SHALL have ports frame_active_o, output, 1, and line_error_o, output, 1, the latter a one-cycle pulse.
REQ-012 SHALL have port err_count_o, output, 8, a saturating error counter.

Function
REQ-013 SHALL implement FSM states IDLE, FRAME and LINE.
REQ-014 SHALL take these transitions: IDLE->FRAME on fv_start_i; FRAME->LINE on lv_start_i; LINE->FRAME on lv_end_i; FRAME or LINE->IDLE on fv_end_i.
REQ-015 SHALL, when events coincide in one cycle, process them in priority fv_start_i > fv_end_i > lv_start_i > lv_end_i and ignore the lower-priority ones.
REQ-016 SHALL assert sp_en_o for exactly one cycle, one cycle after an accepted fv_start_i or fv_end_i.
REQ-017 SHALL assert lp_en_o for exactly one cycle, one cycle after an accepted lv_start_i.
REQ-018 SHALL register dt_o on the same edge as its strobe: 6'h00 on FS, 6'h01 on FE, 6'h2B on line start; dt_o holds its value otherwise.
REQ-019 SHALL register wc_o = WC on line start and wc_o = 0 on FS/FE (see Configuration); wc_o holds otherwise.
REQ-020 SHALL delay byte_en_o and byte_data_o by exactly DATA_DELAY cycles from the inputs, with no gaps or reordering.
REQ-021 SHALL keep a 16-bit byte counter: cleared on lv_start_i, incremented per byte_en_i in LINE.
REQ-022 SHALL pulse line_error_o and increment err_count_o if the byte counter != WC at lv_end_i.
REQ-023 SHALL ignore byte_en_i outside LINE for counting; a byte_en_i on the same cycle as lv_start_i is counted.
REQ-024 SHALL, on fv_start_i while in FRAME or LINE, restart the frame (emit FS) and pulse line_error_o.
REQ-025 SHALL, on fv_end_i while in LINE, emit FE, pulse line_error_o, and not compare the byte count.
REQ-026 SHALL ignore lv_start_i and lv_end_i in IDLE, and lv_start_i in LINE, with no output change and no error.
REQ-027 SHALL saturate err_count_o at 8'hFF, with no wrap-around.
REQ-028 SHALL drive frame_active_o = 1 in FRAME or LINE, and 0 otherwise.

Reset
REQ-029 SHALL, while reset is high, drive FSM to IDLE, all strobes 0, dt_o 0, wc_o 0, err_count_o 0, counters 0, and the delay pipeline to all-zero (byte_en_o 0, byte_data_o 0).
REQ-030 SHALL, on reset mid-line, abandon the line silently, emit no FE, and flush delayed bytes (none are output).

Configuration
REQ-031 SHALL use macro CSI_FRAME_NUMBER_EN.
REQ-032 SHALL, when CSI_FRAME_NUMBER_EN is defined, keep a 16-bit frame number: 1 after reset, incremented after each FE, wrapping 16'hFFFF->1 (never 0); FS and FE wc_o carry the current frame number.
REQ-033 SHALL, when CSI_FRAME_NUMBER_EN is undefined, always drive wc_o = 0 for FS/FE and contain no frame-number register.

Structure
REQ-034 SHALL place in shared package csi_pkg: the FSM state enum, the DT constants (DT_FS=6'h00, DT_FE=6'h01, DT_RAW10=6'h2B) and the default WC.
REQ-035 SHALL implement the byte-path delay as sub-module csi_delay_line, parameterised by width and depth.

Verification
REQ-036 SHALL verify: one frame of 8 lines x 320 bytes -> FS dt 00, 8 lp_en_o with dt 2B and wc 320, FE dt 01, no line_error_o, bytes delayed exactly 3 cycles.
REQ-037 SHALL verify: a line of 319 bytes then lv_end_i -> line_error_o pulse and err_count_o = 1.
REQ-038 SHALL verify: fv_start_i and lv_start_i in the same cycle -> only sp_en_o with dt 00, and the FSM in FRAME.
REQ-039 SHALL verify: fv_end_i mid-line -> FE emitted, line_error_o pulses, FSM to IDLE.
REQ-040 SHALL verify: reset asserted after 100 bytes of a line -> all outputs 0 next cycle and no residual byte_en_o.
REQ-041 SHALL verify, with CSI_FRAME_NUMBER_EN: three frames -> FS/FE wc_o 1, 2, 3; forcing 16'hFFFF -> next frame uses 1.
